key_conditioner: RTL and testbench

Input-conditioning stage that sits directly upstream of the shift-add multiplier. It takes the raw, bouncing, active-low push-button keys and the raw slide switches from the board pins. It produces clean, clock-synchronous signals:
- debounced active-low button levels, which drive the multiplier's run and clearA_loadB inputs;
- single-cycle press and release pulses;
- a synchronized switch bus, which drives the multiplier's S input.

---
 rtl/key_conditioner.sv | 88 ++++++++
 tb/tb_key_conditioner.sv | 136 +++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// key_conditioner: synchronizes and debounces active-low keys into clean levels plus
// press/release pulses, and double-flop synchronizes the switch bus.
module key_conditioner #(
    parameter int N_BTN           = 2,
    parameter int SW_W            = 8,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_n,
    input  logic [SW_W-1:0]  sw,
    output logic [N_BTN-1:0] btn_level_n,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [SW_W-1:0]  sw_sync
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    typedef enum logic [1:0] {REL, CNT_P, PRS, CNT_R} state_t;
    logic [SW_W-1:0] sw_meta;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    genvar i;
    generate
        for (i = 0; i < N_BTN; i++) begin : g_btn
            logic          sync1, sync2, stable, stable_nxt, press, press_nxt, rls, rls_nxt, done;
            logic [CW-1:0] count, count_nxt;
            state_t        state, state_nxt;
            always_ff @(posedge clk or negedge reset)
                if (!reset) begin
                    sync1  <= 1'b1;
                    sync2  <= 1'b1;
                    stable <= 1'b1;
                    count  <= '0;
                    state  <= REL;
                    press  <= 1'b0;
                    rls    <= 1'b0;
                end else begin
                    sync1  <= btn_n[i];
                    sync2  <= sync1;
                    stable <= stable_nxt;
                    count  <= count_nxt;
                    state  <= state_nxt;
                    press  <= press_nxt;
                    rls    <= rls_nxt;
                end
            // The idle state's counter is 0, so entering a count and continuing one share a path.
            always_comb begin
                state_nxt  = state;
                count_nxt  = '0;
                stable_nxt = stable;
                press_nxt  = 1'b0;
                rls_nxt    = 1'b0;
                done       = count == CW'(DEBOUNCE_CYCLES - 1);
                case (state)
                    REL, CNT_P:
                        if (sync2) state_nxt = REL;
                        else if (done) begin
                            stable_nxt = 1'b0;
                            press_nxt  = 1'b1;
                            state_nxt  = PRS;
                        end else begin
                            count_nxt = count + 1'b1;
                            state_nxt = CNT_P;
                        end
                    PRS, CNT_R:
                        if (!sync2) state_nxt = PRS;
                        else if (done) begin
                            stable_nxt = 1'b1;
                            rls_nxt    = 1'b1;
                            state_nxt  = REL;
                        end else begin
                            count_nxt = count + 1'b1;
                            state_nxt = CNT_R;
                        end
                endcase
            end
            assign btn_level_n[i] = stable;
            assign btn_press[i]   = press;
            assign btn_release[i] = rls;
        end
    endgenerate
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed scenarios plus randomized key/switch activity against
// a sample-history reference model.
module tb_key_conditioner;
    localparam int D = 4;
    logic       clk = 1'b0, reset = 1'b0;
    logic [1:0] btn_n = 2'b11;
    logic [7:0] sw = 8'd0;
    logic [1:0] btn_level_n, btn_press, btn_release;
    logic [7:0] sw_sync;
    key_conditioner #(.N_BTN(2), .SW_W(8), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .btn_n(btn_n), .sw(sw),
        .btn_level_n(btn_level_n), .btn_press(btn_press),
        .btn_release(btn_release), .sw_sync(sw_sync)
    );
    always #5 clk = ~clk;
    // Model: a level flips once the last D synchronized samples all disagree with it.
    bit         hist [2][D+2];
    logic [1:0] m_lvl = 2'b11, m_press = 2'b00, m_rel = 2'b00;
    logic [7:0] m_sw = 8'd0, sw_h = 8'd0;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < 2; c++)
                for (int k = 0; k < D + 2; k++) hist[c][k] = 1'b1;
            m_lvl = 2'b11; m_press = 2'b00; m_rel = 2'b00; m_sw = 8'd0; sw_h = 8'd0;
        end else begin
            m_press = 2'b00; m_rel = 2'b00;
            for (int c = 0; c < 2; c++) begin
                bit all_diff;
                for (int k = D + 1; k > 0; k--) hist[c][k] = hist[c][k-1];
                hist[c][0] = btn_n[c];
                all_diff = 1'b1;
                for (int k = 2; k <= D + 1; k++) if (hist[c][k] == m_lvl[c]) all_diff = 1'b0;
                if (all_diff) begin
                    m_lvl[c] = ~m_lvl[c];
                    if (m_lvl[c]) m_rel[c] = 1'b1; else m_press[c] = 1'b1;
                end
            end
            m_sw = sw_h;
            sw_h = sw;
        end
    end
    int n_checks = 0, n_fail = 0, cyc = 0;
    int pc [2], rc [2], first_press [2], first_rel [2];
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask
    task automatic clr();
        cyc = 0;
        for (int c = 0; c < 2; c++) begin
            pc[c] = 0; rc[c] = 0; first_press[c] = -1; first_rel[c] = -1;
        end
    endtask
    task automatic step(int n);
        repeat (n) begin
            @(negedge clk);
            cyc++;
            check("level", 32'(btn_level_n), 32'(m_lvl));
            check("press", 32'(btn_press), 32'(m_press));
            check("release", 32'(btn_release), 32'(m_rel));
            check("sw_sync", 32'(sw_sync), 32'(m_sw));
            check("press_rel_overlap", 32'(btn_press & btn_release), 0);
            for (int c = 0; c < 2; c++) begin
                pc[c] += int'(btn_press[c]);
                rc[c] += int'(btn_release[c]);
                if (btn_press[c] && first_press[c] < 0) first_press[c] = cyc;
                if (btn_release[c] && first_rel[c] < 0) first_rel[c] = cyc;
            end
        end
    endtask
    initial begin
        bit v [5] = '{0, 1, 0, 1, 0};
        clr();
        btn_n = 2'b00; sw = 8'd243;
        repeat (5) begin
            step(1);
            check("rst_level", 32'(btn_level_n), 3);
            check("rst_pulses", 32'(btn_press | btn_release), 0);
            check("rst_sw", 32'(sw_sync), 0);
        end
        reset = 1'b1; btn_n = 2'b10; sw = 8'd0; clr();
        step(20);
        check("clean_press_edge", first_press[0], 6);
        check("clean_press_count", pc[0], 1);
        check("clean_other_quiet", pc[1], 0);
        check("clean_other_level", 32'(btn_level_n[1]), 1);
        clr();
        for (int k = 0; k < 5; k++) begin
            btn_n[1] = v[k];
            step(1);
        end
        step(15);
        check("bounce_press_count", pc[1], 1);
        check("bounce_press_edge", first_press[1], 10);
        btn_n = 2'b11; step(12);
        clr();
        btn_n[1] = 1'b0; step(3); btn_n = 2'b11; step(10);
        check("glitch_press", pc[1], 0);
        check("glitch_release", rc[1], 0);
        check("glitch_level", 32'(btn_level_n), 3);
        clr(); btn_n = 2'b00; step(12);
        check("simul_press0", first_press[0], 6);
        check("simul_press1", first_press[1], 6);
        check("simul_press_cnt", pc[0] + pc[1], 2);
        clr(); btn_n = 2'b11; step(12);
        check("simul_rel0", first_rel[0], 6);
        check("simul_rel1", first_rel[1], 6);
        check("simul_level", 32'(btn_level_n), 3);
        clr(); btn_n = 2'b10; step(3);
        reset = 1'b0; step(2);
        check("midrst_no_pulse", pc[0], 0);
        reset = 1'b1; clr(); step(10);
        check("midrst_requal", first_press[0], 6);
        check("midrst_count", pc[0], 1);
        btn_n = 2'b11; step(12);
        sw = 8'd243; step(2);
        check("sw_243", 32'(sw_sync), 243);
        sw = 8'd3; step(1);
        check("sw_hold", 32'(sw_sync), 243);
        step(1);
        check("sw_3", 32'(sw_sync), 3);
        check("sw_btn_level", 32'(btn_level_n), 3);
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < 2; c++) if ($urandom_range(7) == 0) btn_n[c] = ~btn_n[c];
            if ($urandom_range(3) == 0) sw = 8'($urandom);
            if ($urandom_range(499) == 0) reset = 1'b0;
            else if (!reset && $urandom_range(1) == 0) reset = 1'b1;
            step(1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
